// File: rtl/ysyx_22051468_fetch_ctrl_pkg.sv
// Shared fetch-stage constants and the fetch FSM state encoding.
package ysyx_22051468_fetch_ctrl_pkg;

  localparam int unsigned       FETCH_XLEN       = 64;
  localparam int unsigned       FETCH_INST_WIDTH = 32;
  localparam logic [63:0]       FETCH_RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [31:0]       FETCH_INST_NOP   = 32'h0000_0013;

  // REQ: request on the bus, WAIT: one request outstanding,
  // HOLD: response parked in the skid entry, DROP: discard the stale response.
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ysyx_22051468_Dff.sv
// Reset-value flip-flop with write enable; synchronous active-high reset.
module ysyx_22051468_Dff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  // Load the reset value on rst, otherwise capture din when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_o <= RESET_VAL;
    end else if (wen_i) begin
      dout_o <= din_i;
    end
  end

endmodule

// File: rtl/ysyx_22051468_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, keeps at most one request in
// flight, and presents instruction + PC to decode with stall and redirect
// handling. Define YSYX_22051468_FETCH_PERF_EN to add fetch/stall counters.
module ysyx_22051468_fetch_ctrl
  import ysyx_22051468_fetch_ctrl_pkg::*;
#(
  parameter int unsigned           WIDTH      = FETCH_XLEN,
  parameter int unsigned           INST_WIDTH = FETCH_INST_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_PC   = FETCH_RESET_PC,
  parameter logic [INST_WIDTH-1:0] INST_NOP   = FETCH_INST_NOP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [WIDTH-1:0]      redirect_pc,
  input  logic                  stall,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [WIDTH-1:0]      imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0]      inst_o_addr,
  output logic                  inst_o_valid
`ifdef YSYX_22051468_FETCH_PERF_EN
  ,
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_stall_cnt
`endif
);

  fetch_state_e          state_q, state_d;
  logic [WIDTH-1:0]      pc_q, pc_d;
  logic                  pc_wen;
  logic [INST_WIDTH-1:0] skid_q, skid_d;
  logic [INST_WIDTH-1:0] inst_d;
  logic                  inst_wen;
  logic [WIDTH-1:0]      inst_addr_d;
  logic                  addr_wen;
  logic                  valid_q, valid_d;
  logic                  req_fire;
  logic                  outstanding;

  assign imem_req_valid = (state_q == FETCH_REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inst_o_valid   = valid_q;

  // A request is still in flight after this edge unless its response
  // arrives in the same cycle; a fresh acceptance always leaves one.
  assign outstanding = (((state_q == FETCH_WAIT) || (state_q == FETCH_DROP)) && !imem_rsp_valid)
                       || req_fire;

  // Next-state, PC and output-slot update; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_wen      = 1'b0;
    skid_d      = skid_q;
    inst_d      = INST_NOP;
    inst_addr_d = pc_q;
    addr_wen    = 1'b0;
    if (stall) begin
      valid_d  = valid_q;
      inst_wen = 1'b0;
    end else begin
      valid_d  = 1'b0;
      inst_wen = 1'b1;
    end

    case (state_q)
      FETCH_REQ: begin
        if (req_fire) begin
          state_d = FETCH_WAIT;
        end else begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          if (valid_q && stall) begin
            skid_d  = imem_rsp_data;
            state_d = FETCH_HOLD;
          end else begin
            inst_d   = imem_rsp_data;
            inst_wen = 1'b1;
            addr_wen = 1'b1;
            valid_d  = 1'b1;
            pc_d     = pc_q + WIDTH'(4);
            pc_wen   = 1'b1;
            state_d  = FETCH_REQ;
          end
        end else begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_HOLD: begin
        if (!stall) begin
          inst_d   = skid_q;
          inst_wen = 1'b1;
          addr_wen = 1'b1;
          valid_d  = 1'b1;
          pc_d     = pc_q + WIDTH'(4);
          pc_wen   = 1'b1;
          state_d  = FETCH_REQ;
        end else begin
          state_d = FETCH_HOLD;
        end
      end
      FETCH_DROP: begin
        if (imem_rsp_valid) begin
          state_d = FETCH_REQ;
        end else begin
          state_d = FETCH_DROP;
        end
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      pc_wen   = 1'b1;
      inst_d   = INST_NOP;
      inst_wen = 1'b1;
      addr_wen = 1'b0;
      valid_d  = 1'b0;
      skid_d   = '0;
      if (outstanding) begin
        state_d = FETCH_DROP;
      end else begin
        state_d = FETCH_REQ;
      end
    end else begin
      pc_d = pc_d;
    end
  end

  // FSM state, output-valid flag and skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      valid_q <= 1'b0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
    end
  end

  ysyx_22051468_Dff #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk_i  (clk),
    .rst_i  (rst),
    .wen_i  (pc_wen),
    .din_i  (pc_d),
    .dout_o (pc_q)
  );

  ysyx_22051468_Dff #(
    .WIDTH     (INST_WIDTH),
    .RESET_VAL (INST_NOP)
  ) u_inst (
    .clk_i  (clk),
    .rst_i  (rst),
    .wen_i  (inst_wen),
    .din_i  (inst_d),
    .dout_o (inst_o)
  );

  ysyx_22051468_Dff #(
    .WIDTH     (WIDTH),
    .RESET_VAL ({WIDTH{1'b0}})
  ) u_inst_addr (
    .clk_i  (clk),
    .rst_i  (rst),
    .wen_i  (addr_wen),
    .din_i  (inst_addr_d),
    .dout_o (inst_o_addr)
  );

`ifdef YSYX_22051468_FETCH_PERF_EN
  logic [63:0] perf_fetch_q;
  logic [63:0] perf_stall_q;

  // Count instructions delivered to decode and cycles decode sits stalled on one.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 64'd0;
      perf_stall_q <= 64'd0;
    end else begin
      if (addr_wen) begin
        perf_fetch_q <= perf_fetch_q + 64'd1;
      end else begin
        perf_fetch_q <= perf_fetch_q;
      end
      if (stall && valid_q) begin
        perf_stall_q <= perf_stall_q + 64'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22051468_fetch_ctrl.sv
// Directed scoreboard bench for the fetch controller.
module tb_ysyx_22051468_fetch_ctrl;
  import ysyx_22051468_fetch_ctrl_pkg::*;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst_o;
  logic [63:0] inst_o_addr;
  logic        inst_o_valid;
`ifdef YSYX_22051468_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  ysyx_22051468_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_o         (inst_o),
    .inst_o_addr    (inst_o_addr),
    .inst_o_valid   (inst_o_valid)
`ifdef YSYX_22051468_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    return addr[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Pop the next expected delivery and compare it with the decode outputs.
  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_sb_empty: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, 64'(inst_o_valid), 64'd1);
      check({tag, "_inst"},  64'(inst_o),       64'(e.inst));
      check({tag, "_addr"},  inst_o_addr,       e.addr);
    end
  endtask

  // One unstalled fetch with a 1-cycle memory, starting in REQ.
  task automatic do_fetch(input string tag, input logic [63:0] addr);
    exp_t e;
    check({tag, "_reqv"}, 64'(imem_req_valid), 64'd1);
    check({tag, "_reqa"}, imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check({tag, "_wait_reqv"}, 64'(imem_req_valid), 64'd0);
    check({tag, "_gap_valid"}, 64'(inst_o_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(addr);
    e.addr = addr;
    e.inst = mem_word(addr);
    sb_q.push_back(e);
    tick();
    imem_rsp_valid = 1'b0;
    check_out(tag);
  endtask

  initial begin
    exp_t e;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    tick();
    tick();

    // Reset state.
    check("rst_inst",  64'(inst_o), 64'(FETCH_INST_NOP));
    check("rst_addr",  inst_o_addr, 64'd0);
    check("rst_valid", 64'(inst_o_valid), 64'd0);
    check("rst_reqv",  64'(imem_req_valid), 64'd0);
    check("rst_reqa",  imem_req_addr, 64'h8000_0000);
    rst = 1'b0;
    #1;

    // Three back-to-back fetches.
    for (int i = 0; i < 3; i++) begin
      do_fetch("seq", 64'h8000_0000 + 64'(4 * i));
    end

    // Memory not ready for three cycles: request held stable.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_reqv", 64'(imem_req_valid), 64'd1);
      check("hold_reqa", imem_req_addr, 64'h8000_000C);
    end
    do_fetch("after_hold", 64'h8000_000C);

    // Response arrives while decode is stalled on a valid instruction.
    stall          = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("stall_valid", 64'(inst_o_valid), 64'd1);
    check("stall_addr",  inst_o_addr, 64'h8000_000C);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0;
    check("skid_state", 64'(dut.state_q), 64'(FETCH_HOLD));
    check("skid_inst",  64'(inst_o), 64'(mem_word(64'h8000_000C)));
    check("skid_valid", 64'(inst_o_valid), 64'd1);
    check("skid_reqv",  64'(imem_req_valid), 64'd0);
    tick();
    check("skid_inst2", 64'(inst_o), 64'(mem_word(64'h8000_000C)));
    stall  = 1'b0;
    e.addr = 64'h8000_0010;
    e.inst = 32'h0010_0093;
    sb_q.push_back(e);
    tick();
    check_out("skid_out");
    check("skid_next_reqa", imem_req_addr, 64'h8000_0014);

    // Redirect (with stall) while a request is outstanding.
    stall          = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("redir_pre_valid", 64'(inst_o_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check("redir_inst",  64'(inst_o), 64'(FETCH_INST_NOP));
    check("redir_valid", 64'(inst_o_valid), 64'd0);
    check("redir_state", 64'(dut.state_q), 64'(FETCH_DROP));
    check("redir_reqv",  64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("drop_valid", 64'(inst_o_valid), 64'd0);
    check("drop_inst",  64'(inst_o), 64'(FETCH_INST_NOP));
    do_fetch("redir_fetch", 64'h8000_0100);

    // Reset while waiting; the late response must be ignored.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst_reqv",  64'(imem_req_valid), 64'd0);
    check("mrst_valid", 64'(inst_o_valid), 64'd0);
    check("mrst_addr",  inst_o_addr, 64'd0);
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    check("late_valid", 64'(inst_o_valid), 64'd0);
    check("late_inst",  64'(inst_o), 64'(FETCH_INST_NOP));
    check("late_state", 64'(dut.state_q), 64'(FETCH_REQ));
    do_fetch("post_rst", 64'h8000_0000);

    // PC wraps at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_state", 64'(dut.state_q), 64'(FETCH_REQ));
    do_fetch("wrap", 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_reqa", imem_req_addr, 64'd0);

    // Ten fetches then four stalled-valid cycles from a clean reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      do_fetch("perf", 64'h8000_0000 + 64'(4 * i));
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("perf_hold_addr", inst_o_addr, 64'h8000_0024);
    end
    stall = 1'b0;
    tick();
    check("perf_release_valid", 64'(inst_o_valid), 64'd0);
`ifdef YSYX_22051468_FETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt, 64'd10);
    check("perf_stall_cnt", perf_stall_cnt, 64'd4);
`endif
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22051468_fetch_ctrl.md
Name: ysyx_22051468_fetch_ctrl

Overview:
- Sequences the instruction-fetch stage: owns the PC, issues one request at a time to the instruction memory, and presents instruction + PC to the IF/ID boundary.
- Handles the decode-stage stall and branch/exception redirects, including a redirect that arrives while a request is outstanding.
- Sits between the PC/redirect sources, the instruction ROM port and the decode stage. Replaces the free-running always-enabled fetch register pair.

Parameters:
- WIDTH, 64, address/PC width
- INST_WIDTH, 32, instruction width
- RESET_PC, 64'h8000_0000, first fetch address after reset
- INST_NOP, 32'h0000_0013, instruction presented when no valid instruction is held

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  branch/exception redirect this cycle
- redirect_pc  in  WIDTH  redirect target
- stall  in  1  decode cannot accept; hold current output
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  WIDTH  fetch address
- imem_rsp_valid  in  1  response valid (one per accepted request, latency >= 1)
- imem_rsp_data  in  INST_WIDTH  fetched instruction
- inst_o  out  INST_WIDTH  instruction to decode
- inst_o_addr  out  WIDTH  PC of inst_o
- inst_o_valid  out  1  inst_o/inst_o_addr meaningful

Behaviour:
- Reset (rst=1 at an edge): state=REQ, pc=RESET_PC, inst_o=INST_NOP, inst_o_addr=0, inst_o_valid=0, imem_req_valid=0 during the reset cycle. Reset mid-transaction abandons any outstanding request. A late response arriving after reset is ignored, because the state after reset is REQ, not WAIT.
- imem_req_addr = pc always. imem_req_valid = (state==REQ) && !rst.
- REQ: the request is accepted when imem_req_valid && imem_req_ready; then go to WAIT. The request is held stable until accepted.
- WAIT: on imem_rsp_valid, load inst_o=imem_rsp_data, inst_o_addr=pc, inst_o_valid=1, pc=pc+4, then go to REQ.
  - If the output slot is still occupied and stalled (inst_o_valid && stall) when the response arrives, park the data in a one-entry skid register and go to HOLD.
- HOLD: when stall deasserts, move the skid entry to the outputs, pc=pc+4, then go to REQ.
- Output handshake: while stall=1, inst_o/inst_o_addr/inst_o_valid are held unchanged. While stall=0 and no new response is loaded, inst_o_valid clears to 0 and inst_o becomes INST_NOP after one cycle.
- Redirect (highest priority after rst), in any state:
  - pc=redirect_pc.
  - inst_o_valid=0, inst_o=INST_NOP, and the skid entry is discarded.
  - If a request is outstanding (WAIT, or REQ accepted in the same cycle), go to DROP. Otherwise go to REQ.
- DROP: wait for the single outstanding response and discard it, then go to REQ. A second redirect during DROP only updates pc.
- Redirect together with stall: the redirect wins and the outputs are flushed.
- Latency: best case 2 cycles from request acceptance to inst_o_valid with a 1-cycle memory. Throughput is 1 instruction per 2 cycles; no request pipelining.
- PC arithmetic wraps modulo 2^WIDTH. The low 2 bits of redirect_pc are passed through unchecked.
- States: REQ, WAIT, HOLD, DROP (2-bit encoding).

Optional Feature:
- Macro: YSYX_22051468_FETCH_PERF_EN.
- With the macro defined:
  - Adds outputs perf_fetch_cnt (64), incremented on every response loaded to the outputs.
  - Adds perf_stall_cnt (64), incremented every cycle stall && inst_o_valid.
  - Both counters clear on rst and wrap.
- Without the macro: no counter ports and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package/include (INST_TYPE.v): INST_WIDTH, INST_NOP, RESET_PC, and the fetch-state encodings (FETCH_REQ, FETCH_WAIT, FETCH_HOLD, FETCH_DROP).
- Sub-module: the existing reset-value/enable flip-flop (ysyx_22051468_Dff) is instantiated for pc, inst_o and inst_o_addr with wen driven by this controller. Its reset becomes synchronous active-high here.
- The FSM stays inline.

Test Plan:
- Reset, memory ready=1, rsp latency 1 -> requests at 0x80000000, 0x80000004, 0x80000008. inst_o_addr follows the same sequence, inst_o_valid pulses every 2nd cycle.
- imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1 and imem_req_addr stays constant. Exactly one acceptance follows.
- stall=1 with inst_o_valid=1, response 0x00100093 arrives -> outputs hold the prior instruction and state is HOLD. After stall=0, next cycle inst_o=0x00100093.
- Redirect to 0x80000100 while in WAIT -> outputs flush to INST_NOP/valid=0. The in-flight response is dropped, and the next request is to 0x80000100.
- rst asserted in WAIT, response arrives the next cycle -> response ignored, first request after reset is to 0x80000000.
- With PERF_EN: 10 fetches and 4 stalled-valid cycles -> perf_fetch_cnt=10, perf_stall_cnt=4.
